// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 16;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_det_cmp.sv
// Masked pattern comparator: only the low len bits of history/pattern take part.
module seq_det_cmp #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic [MAX_LEN-1:0] history,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

  logic [MAX_LEN-1:0] mask;

  // Thermometer mask: bit i is live when i < len.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(len));
  end

  assign match = (((history ^ pattern) & mask) == '0);

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap select and
// saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic               i_data,
  input  logic               i_cnt_clr,
  output logic               o_pattern_found,
  output logic [CNT_W-1:0]   o_match_cnt,
  output logic               o_cfg_err,
  output logic               o_armed
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, hist_sh;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic               found_d, err_d, cfg_ok, cmp_match;

  assign hist_sh = {hist_q[MAX_LEN-2:0], i_data};
  assign cfg_ok  = (i_cfg_len != '0) && (i_cfg_len <= LEN_W'(MAX_LEN));

  // Compare against the post-shift history so the bit arriving now counts.
  seq_det_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_cmp (
    .history (hist_sh),
    .pattern (pat_q),
    .len     (len_q),
    .match   (cmp_match)
  );

  // Next-state: config load first, then enable, then the fill/run datapath.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    found_d = 1'b0;
    err_d   = 1'b0;
    if (i_cfg_load) begin
      // Load cycle never consumes the data bit.
      if (cfg_ok) begin
        pat_d   = i_cfg_pattern;
        len_d   = i_cfg_len;
        ovl_d   = i_cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
        state_d = i_enable ? S_FILL : S_IDLE;
      end else begin
        err_d = 1'b1;
        if (!i_enable) begin
          state_d = S_IDLE;
          hist_d  = '0;
          fill_d  = '0;
        end
      end
    end else if (!i_enable) begin
      state_d = S_IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_FILL;
        S_FILL: if (i_valid) begin
          hist_d = hist_sh;
          fill_d = fill_q + 1'b1;
          // The len-th bit is already eligible to match.
          if (fill_d == len_q) begin
            found_d = cmp_match;
            if (cmp_match && ovl_q == MODE_NONOVL) fill_d = '0;
            else                                   state_d = S_RUN;
          end
        end
        S_RUN: if (i_valid) begin
          hist_d  = hist_sh;
          found_d = cmp_match;
          if (cmp_match && ovl_q == MODE_NONOVL) begin
            fill_d  = '0;
            state_d = S_FILL;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, config and output registers; clear beats increment, count saturates.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q         <= S_IDLE;
      hist_q          <= '0;
      fill_q          <= '0;
      pat_q           <= '0;
      len_q           <= LEN_W'(1);
      ovl_q           <= MODE_OVL;
      o_pattern_found <= 1'b0;
      o_cfg_err       <= 1'b0;
      o_match_cnt     <= '0;
    end else begin
      state_q         <= state_d;
      hist_q          <= hist_d;
      fill_q          <= fill_d;
      pat_q           <= pat_d;
      len_q           <= len_d;
      ovl_q           <= ovl_d;
      o_pattern_found <= found_d;
      o_cfg_err       <= err_d;
      if (i_cnt_clr)                         o_match_cnt <= '0;
      else if (found_d && o_match_cnt != '1) o_match_cnt <= o_match_cnt + 1'b1;
    end
  end

  assign o_armed = (state_q == S_RUN);

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog (MAX_LEN=16, CNT_W=2).
module tb_seq_detector_prog;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN+1);

  logic               i_clk = 1'b0;
  logic               i_resetn, i_cfg_load, i_cfg_overlap, i_enable;
  logic               i_valid, i_data, i_cnt_clr;
  logic [MAX_LEN-1:0] i_cfg_pattern;
  logic [LEN_W-1:0]   i_cfg_len;
  logic               o_pattern_found, o_cfg_err, o_armed;
  logic [CNT_W-1:0]   o_match_cnt;

  int n_cmp = 0;
  int n_err = 0;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .i_clk           (i_clk),
    .i_resetn        (i_resetn),
    .i_cfg_load      (i_cfg_load),
    .i_cfg_pattern   (i_cfg_pattern),
    .i_cfg_len       (i_cfg_len),
    .i_cfg_overlap   (i_cfg_overlap),
    .i_enable        (i_enable),
    .i_valid         (i_valid),
    .i_data          (i_data),
    .i_cnt_clr       (i_cnt_clr),
    .o_pattern_found (o_pattern_found),
    .o_match_cnt     (o_match_cnt),
    .o_cfg_err       (o_cfg_err),
    .o_armed         (o_armed)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic d, input logic exp_found, input string tag);
    i_valid = 1'b1;
    i_data  = d;
    tick();
    i_valid = 1'b0;
    chk(tag, 16'(o_pattern_found), 16'(exp_found));
  endtask

  task automatic load(input logic [15:0] pat, input logic [LEN_W-1:0] len,
                      input logic ovl, input logic exp_err, input string tag);
    i_cfg_load    = 1'b1;
    i_cfg_pattern = pat;
    i_cfg_len     = len;
    i_cfg_overlap = ovl;
    tick();
    i_cfg_load = 1'b0;
    chk(tag, 16'(o_cfg_err), 16'(exp_err));
  endtask

  task automatic clr();
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    chk("cnt_clr", 16'(o_match_cnt), 16'd0);
  endtask

  initial begin
    i_resetn = 0; i_cfg_load = 0; i_cfg_pattern = '0; i_cfg_len = '0;
    i_cfg_overlap = 0; i_enable = 0; i_valid = 0; i_data = 0; i_cnt_clr = 0;
    tick(); tick();
    chk("rst_found", 16'(o_pattern_found), 16'd0);
    chk("rst_cnt",   16'(o_match_cnt),     16'd0);
    chk("rst_err",   16'(o_cfg_err),       16'd0);
    chk("rst_armed", 16'(o_armed),         16'd0);
    i_resetn = 1;
    i_enable = 1;

    // 1: 6-bit pattern 101001, overlap
    load(16'b101001, 5'd6, 1'b1, 1'b0, "t1_err");
    send(1, 0, "t1_b1"); send(0, 0, "t1_b2"); send(1, 0, "t1_b3");
    send(0, 0, "t1_b4"); send(0, 0, "t1_b5"); send(1, 1, "t1_b6");
    chk("t1_cnt", 16'(o_match_cnt), 16'd1);
    tick();
    chk("t1_novalid", 16'(o_pattern_found), 16'd0);
    chk("t1_armed",   16'(o_armed),         16'd1);

    // 2: overlap, 101 with garbage above len
    clr();
    load(16'hFFFD, 5'd3, 1'b1, 1'b0, "t2_err");
    send(1, 0, "t2_b1"); send(0, 0, "t2_b2"); send(1, 1, "t2_b3");
    send(0, 0, "t2_b4"); send(1, 1, "t2_b5");
    chk("t2_cnt", 16'(o_match_cnt), 16'd2);

    // 3: non-overlap, 101
    clr();
    load(16'b101, 5'd3, 1'b0, 1'b0, "t3_err");
    send(1, 0, "t3_b1"); send(0, 0, "t3_b2"); send(1, 1, "t3_b3");
    chk("t3_armed", 16'(o_armed), 16'd0);
    send(0, 0, "t3_b4"); send(1, 0, "t3_b5");
    chk("t3_cnt1", 16'(o_match_cnt), 16'd1);
    send(1, 0, "t3_b6"); send(0, 0, "t3_b7"); send(1, 1, "t3_b8");
    chk("t3_cnt2", 16'(o_match_cnt), 16'd2);

    // 4: gaps, then enable drop mid-pattern
    clr();
    load(16'b1100, 5'd4, 1'b1, 1'b0, "t4_err");
    send(1, 0, "t4_b1"); send(1, 0, "t4_b2");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_gap", 16'(o_pattern_found), 16'd0);
    end
    send(0, 0, "t4_b3"); send(0, 1, "t4_b4");
    chk("t4_cnt", 16'(o_match_cnt), 16'd1);
    send(1, 0, "t4_b5");
    i_enable = 0; tick();
    chk("t4_dis_armed", 16'(o_armed), 16'd0);
    i_enable = 1; tick();
    send(1, 0, "t4_r1"); send(0, 0, "t4_r2"); send(0, 0, "t4_r3");
    chk("t4_cnt_hold", 16'(o_match_cnt), 16'd1);

    // 5: rejected loads keep config and history
    load(16'hFFFF, 5'd0, 1'b0, 1'b1, "t5_err_len0");
    tick();
    chk("t5_err_pulse", 16'(o_cfg_err), 16'd0);
    load(16'hFFFF, 5'(MAX_LEN+1), 1'b0, 1'b1, "t5_err_len17");
    send(1, 0, "t5_b1"); send(1, 0, "t5_b2"); send(0, 0, "t5_b3"); send(0, 1, "t5_b4");
    chk("t5_cnt", 16'(o_match_cnt), 16'd2);

    // 6: saturation, clear-vs-match, load-vs-valid, mid-stream reset
    clr();
    load(16'h0001, 5'd1, 1'b1, 1'b0, "t6_err");
    send(1, 1, "t6_m1"); chk("t6_c1", 16'(o_match_cnt), 16'd1);
    send(1, 1, "t6_m2"); chk("t6_c2", 16'(o_match_cnt), 16'd2);
    send(1, 1, "t6_m3"); chk("t6_c3", 16'(o_match_cnt), 16'd3);
    send(1, 1, "t6_m4"); chk("t6_c4", 16'(o_match_cnt), 16'd3);
    send(1, 1, "t6_m5"); chk("t6_sat", 16'(o_match_cnt), 16'd3);
    i_cnt_clr = 1;
    send(1, 1, "t6_clr_found");
    i_cnt_clr = 0;
    chk("t6_clr_cnt", 16'(o_match_cnt), 16'd0);
    i_valid = 1; i_data = 1;
    load(16'h0001, 5'd1, 1'b1, 1'b0, "t6_ld_err");
    chk("t6_ld_nofound", 16'(o_pattern_found), 16'd0);
    send(1, 1, "t6_pre_rst");
    i_resetn = 0; i_valid = 1; i_data = 1;
    tick();
    i_valid = 0;
    chk("t6_rst_found", 16'(o_pattern_found), 16'd0);
    chk("t6_rst_cnt",   16'(o_match_cnt),     16'd0);
    chk("t6_rst_armed", 16'(o_armed),         16'd0);
    chk("t6_rst_err",   16'(o_cfg_err),       16'd0);
    // Reset config is pattern=0, len=1, overlap: a single 0 matches.
    i_resetn = 1;
    tick();
    send(1, 0, "t6_rcfg_1"); send(0, 1, "t6_rcfg_0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Runtime-programmable serial pattern detector, the parametrised successor to the fixed 6-bit FSM detectors. It accepts a qualified serial bit stream and matches it against a loadable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping detection is selectable per configuration. It reports a registered one-cycle match pulse and keeps a saturating match count. The block sits between the serial-input front end and the status/interrupt logic.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (legal range 2..64)
CNT_W, 16, width of the match counter
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_resetn  in  1  reset, synchronous, active-low
i_cfg_load  in  1  one-cycle strobe; loads pattern, length and mode
i_cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
i_cfg_len  in  LEN_W  pattern length; legal values 1..MAX_LEN
i_cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
i_enable  in  1  detection enable
i_valid  in  1  qualifies i_data for this cycle
i_data  in  1  serial data bit
i_cnt_clr  in  1  clears the match counter
o_pattern_found  out  1  one-cycle match pulse (registered)
o_match_cnt  out  CNT_W  saturating count of matches
o_cfg_err  out  1  one-cycle pulse when a load is rejected
o_armed  out  1  high while in S_RUN

Behaviour:
- Reset (i_resetn=0 at a clock edge): state=S_IDLE; history=0; fill=0; pattern=0; len=1; overlap=1. All outputs 0.
- State S_IDLE: entered when i_enable=0. History and fill are held at 0. Moves to S_FILL when i_enable=1.
- State S_FILL: each i_valid cycle shifts the history: history <= {history[MAX_LEN-2:0], i_data}, and fill increments. Moves to S_RUN on the cycle fill reaches len.
- State S_RUN: each i_valid cycle shifts the history. The compare uses the post-shift history. A match is history[len-1:0] == pattern[len-1:0]. On a match, o_pattern_found=1 on the following cycle.
- From any state, i_enable=0 returns the block to S_IDLE on the next edge.
- Match latency is exactly 1 clock after the edge that samples the final pattern bit. o_pattern_found is 0 in every other cycle, including cycles where i_valid=0.
- The match on the len-th bit is evaluated in the same cycle that fill reaches len. For example, with len=3, the third valid bit can produce a match.
- Overlap mode: history is kept after a match.
- Non-overlap mode: on a match, fill is cleared to 0 and the state returns to S_FILL. The bits of the matched pattern cannot contribute to the next match.
- Config load is accepted in any state:
  - Valid load: pattern, len and mode update; history and fill clear; state goes to S_FILL if i_enable=1, otherwise S_IDLE. No match pulse is produced from the load cycle's data.
  - i_cfg_len = 0 or > MAX_LEN: the load is rejected and the old config is kept. o_cfg_err pulses 1 cycle later. History is not disturbed.
- Pattern bits above len-1 are ignored.
- Counter: increments on every match and saturates at 2^CNT_W-1 (no wrap).
- i_cnt_clr has priority over the increment in the same cycle; the counter goes to 0 and that match is lost from the count, but o_pattern_found still pulses.
- i_cfg_load and i_valid in the same cycle: the load wins and the data bit is discarded.
- i_valid=0: nothing shifts and the state is held.
- Reset mid-stream returns the block to the reset values on the next edge.

Decomposition:
- Package seq_det_pkg:
  - State encoding: S_IDLE=2'd0, S_FILL=2'd1, S_RUN=2'd2.
  - Default MAX_LEN.
  - Mode constants MODE_NONOVL=1'b0, MODE_OVL=1'b1.
- Sub-module seq_det_cmp: combinational masked comparator with inputs history, pattern and len, and output match. Masking is done with a len-derived thermometer mask. It is kept separate so it can be reused by a future multi-channel version.

Test Plan:
1. Reset, load 6'b101001 with len=6 and overlap=1, enable, stream 1,0,1,0,0,1 -> o_pattern_found pulses once, one cycle after the 6th bit; o_match_cnt=1.
2. Overlap: load 3'b101, overlap=1, stream 1,0,1,0,1 -> pulses after bit 3 and bit 5; count=2.
3. Non-overlap: same pattern with overlap=0, stream 1,0,1,0,1 -> single pulse after bit 3; count=1. Extend the stream with 1,0,1 -> second pulse (count=2).
4. Gaps and enable: load 4'b1100; stream 1,1 then i_valid=0 for 3 cycles, then 0,0 -> one pulse after the last 0. Drop i_enable mid-pattern, re-enable, stream 1,0,0 -> no pulse (fill restarted).
5. Config error: load len=0, then len=MAX_LEN+1 -> o_cfg_err pulses each time; the previous pattern still matches.
6. Counter: set CNT_W=2 and trigger 5 matches -> count saturates at 3. Assert i_cnt_clr in the same cycle as a match -> count=0 and o_pattern_found=1. Assert reset mid-stream -> all outputs 0 on the next cycle.
